// File: rtl/program_sequencer.sv
// Program sequencer: fetches 16-bit words from a synchronous ROM and steps
// control_unit through one run/done handshake per instruction until HALT, stop or timeout.
module program_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [15:0]       instruction,
  output logic              run,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [15:0]       instr_count,
  output logic [2:0]        dbg_state
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_HALT    = 2'b01;
  localparam logic [1:0] CAUSE_STOP    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LATCH  = 3'd2,
    S_EXEC   = 3'd3,
    S_RETIRE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stop_pend_q, stop_pend_d;
  logic [1:0]        cause_q, cause_d;
  logic [15:0]       count_q, count_d;
  logic              rom_en_q, run_q, busy_q, halted_q;

  // Handshake: run is held high for the whole of EXEC and done is only looked at
  // while run is high; the cycle after done is seen, run is low again (RETIRE).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    wait_d      = wait_q;
    cause_d     = cause_q;
    count_d     = count_q;
    stop_pend_d = stop_pend_q | (stop & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          pc_d        = start_addr;
          count_d     = '0;
          cause_d     = CAUSE_NONE;
          stop_pend_d = 1'b0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        instr_d = rom_data;
        wait_d  = '0;
        if (rom_data[1:0] == 2'b11) begin
          state_d = S_IDLE;
          cause_d = CAUSE_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (done) begin
          state_d = S_RETIRE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RETIRE: begin
        pc_d    = pc_q + ADDR_W'(1);
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
        if (stop_pend_q || stop) begin
          state_d = S_IDLE;
          cause_d = CAUSE_STOP;
        end else begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      wait_q      <= '0;
      stop_pend_q <= 1'b0;
      cause_q     <= CAUSE_NONE;
      count_q     <= '0;
      rom_en_q    <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      wait_q      <= wait_d;
      stop_pend_q <= stop_pend_d;
      cause_q     <= cause_d;
      count_q     <= count_d;
      rom_en_q    <= (state_d == S_FETCH);
      run_q       <= (state_d == S_EXEC);
      busy_q      <= (state_d != S_IDLE);
      halted_q    <= (state_q != S_IDLE) && (state_d == S_IDLE);
    end
  end

  assign rom_en      = rom_en_q;
  assign rom_addr    = pc_q;
  assign instruction = instr_q;
  assign run         = run_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign instr_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: ROM and control_unit stand-ins, a cycle-level
// program model built from instruction timings, directed scenarios and random programs.
module tb_program_sequencer;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic        stop;
  logic        rom_en, run, done, busy, halted;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data = '0;
  logic [15:0] instruction, instr_count;
  logic [1:0]  halt_cause;
  logic [2:0]  dbg_state;

  always #5 clk = ~clk;

  program_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .stop(stop),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .instruction(instruction),
    .run(run), .done(done), .busy(busy), .halted(halted), .halt_cause(halt_cause),
    .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // ---------------- ROM and control_unit stand-ins ----------------
  logic [15:0] rom_mem [0:255];
  always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];

  int dly_tab [64];      // done arrives in this EXEC cycle of instruction k; 0 = never
  int stop_idx = -1;
  int stop_off = 0;
  int exec_idx = 0;
  int run_cnt;

  always @(posedge clk or posedge reset)
    if (reset) run_cnt <= 0;
    else if (run) run_cnt <= run_cnt + 1;
    else run_cnt <= 0;

  assign done = run && (exec_idx < 64) && (dly_tab[exec_idx] != 0) && (run_cnt == dly_tab[exec_idx] - 1);
  assign stop = (stop_idx >= 0) && run && (exec_idx == stop_idx) && (run_cnt == stop_off);

  // ---------------- monitor ----------------
  logic [7:0] obs_q[$];
  int ncyc = 0, first_fetch = -1, halted_cyc = -1, halted_cnt = 0, run_cycles = 0;
  logic prev_run = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (rom_en) begin
        obs_q.push_back(rom_addr);
        if (first_fetch < 0) first_fetch = ncyc;
      end
      if (run) run_cycles++;
      if (halted) begin halted_cnt++; halted_cyc = ncyc; end
      if (prev_run && !run) exec_idx++;
    end
    prev_run = run;
    ncyc++;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [7:0]  exp_q[$];
  int          exp_cause, exp_count, exp_pc, exp_halt_t, exp_run;
  logic [15:0] exp_instr;
  int          n_checks = 0, n_pass = 0;

  // Walks the program word by word: HALT costs 2 cycles to IDLE, an executed
  // word costs FETCH+LATCH+d+RETIRE, a word that never gets done costs 2+TIMEOUT.
  task automatic model_program(input int sa);
    int pc, t;
    logic [15:0] w;
    exp_q.delete();
    pc = sa; t = 0; exp_count = 0; exp_run = 0; exp_cause = 0; exp_halt_t = -1;
    for (int idx = 0; idx < 64; idx++) begin
      exp_q.push_back(8'(pc));
      w = rom_mem[pc];
      exp_instr = w;
      if (w[1:0] == 2'b11) begin exp_cause = 1; exp_halt_t = t + 2; break; end
      if (dly_tab[idx] == 0) begin
        exp_run += TIMEOUT; exp_cause = 3; exp_halt_t = t + 2 + TIMEOUT; break;
      end
      exp_run += dly_tab[idx];
      pc = (pc + 1) % 256;
      if (exp_count != 65535) exp_count++;
      if (idx == stop_idx) begin exp_cause = 2; exp_halt_t = t + 3 + dly_tab[idx]; break; end
      t += 3 + dly_tab[idx];
    end
    exp_pc = pc;
  endtask

  function automatic bit fetch_match();
    if (obs_q.size() != exp_q.size()) return 1'b0;
    foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    @(negedge clk); #1;
    obs_q.delete();
    first_fetch = -1; halted_cyc = -1; halted_cnt = 0; run_cycles = 0; exec_idx = 0;
  endtask

  task automatic do_start(input logic [7:0] sa);
    start_addr = sa; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, output bit expired);
    expired = 1'b1;
    repeat (budget) begin
      @(negedge clk); #1;
      if (halted_cnt > 0) begin expired = 1'b0; break; end
    end
  endtask

  task automatic run_prog(input logic [7:0] sa, output bit expired);
    model_program(sa);
    clear_mon();
    do_start(sa);
    wait_halt(400, expired);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int bad = 0;
    bit to;
    rom_mem[0] = 16'h0003;
    reset = 1'b1; start = 1'b1; start_addr = 8'h00;
    repeat (4) begin @(negedge clk); if (rom_en !== 1'b0) bad++; end
    n_checks++; if (bad != 0) $display("FAIL reset_rom_en: got %0d cycles high want 0", bad); else n_pass++;
    n_checks++; if (run !== 1'b0) $display("FAIL reset_run: got %b want 0", run); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    n_checks++; if (halt_cause !== 2'b00) $display("FAIL reset_cause: got %b want 00", halt_cause); else n_pass++;
    n_checks++; if (instr_count !== 16'h0) $display("FAIL reset_count: got %h want 0", instr_count); else n_pass++;
    n_checks++; if (instruction !== 16'h0) $display("FAIL reset_instr: got %h want 0", instruction); else n_pass++;
    n_checks++; if (rom_addr !== 8'h00) $display("FAIL reset_pc: got %h want 00", rom_addr); else n_pass++;
    n_checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    reset = 1'b0;
    @(negedge clk); #1;
    n_checks++; if (rom_en !== 1'b1 || busy !== 1'b1) $display("FAIL start_latency: got rom_en=%b busy=%b want 1 1", rom_en, busy); else n_pass++;
    start = 1'b0;
    wait_halt(50, to);
    n_checks++; if (to || halt_cause !== 2'b01) $display("FAIL reset_run_halt: got timeout=%b cause=%b want 0 01", to, halt_cause); else n_pass++;
  endtask

  task automatic test_single();
    bit to;
    rom_mem[8'h10] = 16'h2410; rom_mem[8'h11] = 16'h0003;
    dly_tab[0] = 6; stop_idx = -1;
    run_prog(8'h10, to);
    n_checks++; if (to) $display("FAIL single_wait: got no halted want halted"); else n_pass++;
    n_checks++; if (run_cycles != 6) $display("FAIL single_run: got %0d want 6", run_cycles); else n_pass++;
    n_checks++; if (instr_count !== 16'd1) $display("FAIL single_count: got %0d want 1", instr_count); else n_pass++;
    n_checks++; if (halt_cause !== 2'b01) $display("FAIL single_cause: got %b want 01", halt_cause); else n_pass++;
    n_checks++; if (rom_addr !== 8'h11) $display("FAIL single_pc: got %h want 11", rom_addr); else n_pass++;
    n_checks++; if (halted_cyc - first_fetch != 11) $display("FAIL single_halt_time: got %0d want 11", halted_cyc - first_fetch); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL single_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if (halted !== 1'b0 || halted_cnt != 1) $display("FAIL single_pulse: got halted=%b count=%0d want 0 1", halted, halted_cnt); else n_pass++;
  endtask

  task automatic test_wrap();
    bit to;
    rom_mem[8'hFF] = 16'h2410; rom_mem[8'h00] = 16'h0003;
    dly_tab[0] = 6; stop_idx = -1;
    run_prog(8'hFF, to);
    n_checks++; if (to || !fetch_match()) $display("FAIL wrap_fetch: got %0d fetches want %0d (FF,00)", obs_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (rom_addr !== 8'h00) $display("FAIL wrap_pc: got %h want 00", rom_addr); else n_pass++;
    n_checks++; if (instr_count !== 16'd1 || halt_cause !== 2'b01) $display("FAIL wrap_end: got count=%0d cause=%b want 1 01", instr_count, halt_cause); else n_pass++;
  endtask

  task automatic test_stop();
    bit to;
    rom_mem[8'h40] = 16'h1234; rom_mem[8'h41] = 16'h5678; rom_mem[8'h42] = 16'h9ABC; rom_mem[8'h43] = 16'h0003;
    for (int i = 0; i < 3; i++) dly_tab[i] = 6;
    stop_idx = 1; stop_off = 2;
    run_prog(8'h40, to);
    n_checks++; if (to || obs_q.size() != 2) $display("FAIL stop_fetches: got %0d want 2", obs_q.size()); else n_pass++;
    n_checks++; if (instr_count !== 16'd2 || halt_cause !== 2'b10) $display("FAIL stop_end: got count=%0d cause=%b want 2 10", instr_count, halt_cause); else n_pass++;
    n_checks++; if (rom_addr !== 8'h42) $display("FAIL stop_pc: got %h want 42", rom_addr); else n_pass++;
    n_checks++; if (halted_cyc - first_fetch != 18) $display("FAIL stop_halt_time: got %0d want 18", halted_cyc - first_fetch); else n_pass++;
    stop_idx = 0; stop_off = 5;   // stop lands in the same cycle as done
    run_prog(8'h40, to);
    n_checks++; if (to || instr_count !== 16'd1 || halt_cause !== 2'b10) $display("FAIL stop_with_done: got count=%0d cause=%b want 1 10", instr_count, halt_cause); else n_pass++;
    stop_idx = -1;
  endtask

  task automatic test_timeout();
    bit to;
    rom_mem[8'h20] = 16'h2410;
    dly_tab[0] = 0; stop_idx = -1;
    run_prog(8'h20, to);
    n_checks++; if (to || run_cycles != TIMEOUT) $display("FAIL timeout_run: got %0d want %0d", run_cycles, TIMEOUT); else n_pass++;
    n_checks++; if (halt_cause !== 2'b11 || instr_count !== 16'd0) $display("FAIL timeout_end: got cause=%b count=%0d want 11 0", halt_cause, instr_count); else n_pass++;
    n_checks++; if (run !== 1'b0 || halted_cyc - first_fetch != TIMEOUT + 2) $display("FAIL timeout_time: got run=%b t=%0d want 0 %0d", run, halted_cyc - first_fetch, TIMEOUT + 2); else n_pass++;
    n_checks++; if (rom_addr !== 8'h20) $display("FAIL timeout_pc: got %h want 20", rom_addr); else n_pass++;
  endtask

  task automatic test_start_busy();
    bit to;
    rom_mem[8'h30] = 16'h1111; rom_mem[8'h31] = 16'h2222; rom_mem[8'h32] = 16'h0003; rom_mem[8'h80] = 16'h0003;
    dly_tab[0] = 6; dly_tab[1] = 6; stop_idx = -1;
    model_program(8'h30);
    clear_mon();
    do_start(8'h30);
    repeat (4) @(negedge clk);
    start_addr = 8'h80; start = 1'b1;
    @(negedge clk);
    start = 1'b0; start_addr = 8'h00;
    wait_halt(100, to);
    n_checks++; if (to || !fetch_match()) $display("FAIL busy_start_fetch: got %0d fetches want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    n_checks++; if (rom_addr !== 8'h32 || instr_count !== 16'd2) $display("FAIL busy_start_end: got pc=%h count=%0d want 32 2", rom_addr, instr_count); else n_pass++;
  endtask

  task automatic test_reset_mid_exec();
    bit seen = 1'b0;
    rom_mem[8'h50] = 16'h2410;
    dly_tab[0] = 0; stop_idx = -1;
    clear_mon();
    do_start(8'h50);
    repeat (20) begin
      @(negedge clk); #1;
      if (run) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) $display("FAIL midreset_run_rise: got run never high want high"); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_checks++; if (run !== 1'b0 || busy !== 1'b0) $display("FAIL midreset_async: got run=%b busy=%b want 0 0", run, busy); else n_pass++;
    n_checks++; if (dbg_state !== 3'd0 || rom_addr !== 8'h00) $display("FAIL midreset_state: got state=%0d pc=%h want 0 00", dbg_state, rom_addr); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit to;
    int sa, n;
    logic [15:0] w;
    for (int it = 0; it < 25; it++) begin
      sa = $urandom_range(0, 255);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        if (w[1:0] == 2'b11) w[0] = 1'b0;
        rom_mem[(sa + i) % 256] = w;
        dly_tab[i] = $urandom_range(1, TIMEOUT);
      end
      w = 16'($urandom); w[1:0] = 2'b11;
      rom_mem[(sa + n) % 256] = w;
      if ($urandom_range(0, 5) == 0) dly_tab[$urandom_range(0, n - 1)] = 0;
      stop_idx = -1;
      if ($urandom_range(0, 3) == 0) begin
        stop_idx = $urandom_range(0, n - 1);
        stop_off = $urandom_range(0, (dly_tab[stop_idx] == 0 ? TIMEOUT : dly_tab[stop_idx]) - 1);
      end
      run_prog(8'(sa), to);
      n_checks++; if (to) $display("FAIL rand%0d_wait: got no halted want halted", it); else n_pass++;
      n_checks++; if (halt_cause !== 2'(exp_cause)) $display("FAIL rand%0d_cause: got %0d want %0d", it, halt_cause, exp_cause); else n_pass++;
      n_checks++; if (instr_count !== 16'(exp_count)) $display("FAIL rand%0d_count: got %0d want %0d", it, instr_count, exp_count); else n_pass++;
      n_checks++; if (rom_addr !== 8'(exp_pc)) $display("FAIL rand%0d_pc: got %h want %h", it, rom_addr, exp_pc); else n_pass++;
      n_checks++; if (run_cycles != exp_run) $display("FAIL rand%0d_run: got %0d want %0d", it, run_cycles, exp_run); else n_pass++;
      n_checks++; if (halted_cyc - first_fetch != exp_halt_t) $display("FAIL rand%0d_halt_time: got %0d want %0d", it, halted_cyc - first_fetch, exp_halt_t); else n_pass++;
      n_checks++; if (!fetch_match()) $display("FAIL rand%0d_fetch: got %0d fetches want %0d", it, obs_q.size(), exp_q.size()); else n_pass++;
      n_checks++; if (instruction !== exp_instr) $display("FAIL rand%0d_instr: got %h want %h", it, instruction, exp_instr); else n_pass++;
    end
    stop_idx = -1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'h0003;
    for (int i = 0; i < 64; i++) dly_tab[i] = 6;
    test_reset();
    test_single();
    test_wrap();
    test_stop();
    test_timeout();
    test_start_busy();
    test_reset_mid_exec();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run want end within 2ms");
    $fatal(1);
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Fetches 16-bit instructions from a synchronous program ROM and drives `control_unit` through its `run`/`done` handshake, one instruction at a time. Holds the program counter, decodes the HALT marker, honours an external stop request, and aborts on a `done` timeout. Sits between the program ROM and `control_unit`. Replaces the manually driven `run`/`instruction` pins at the top level.

## Interface
- `ADDR_W`, 8: ROM address / PC width.
- `TIMEOUT`, 15: maximum EXEC cycles without `done` before abort (≥ 6).
- `clk`  in  1: system clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: level sampled in IDLE; begins execution at `start_addr`.
- `start_addr`  in  ADDR_W: first instruction address.
- `stop`  in  1: request halt after the current instruction retires.
- `rom_en`  out  1: ROM read enable.
- `rom_addr`  out  ADDR_W: ROM address (= PC).
- `rom_data`  in  16: ROM read data, valid the cycle after `rom_en`.
- `instruction`  out  16: to `control_unit.instruction`; stable throughout EXEC.
- `run`  out  1: to `control_unit.run`.
- `done`  in  1: from `control_unit.done`.
- `busy`  out  1: high in every state except IDLE.
- `halted`  out  1: one-cycle pulse on each return to IDLE.
- `halt_cause`  out  2: 00 none, 01 HALT opcode, 10 stop, 11 timeout; held until the next start.
- `instr_count`  out  16: instructions retired since the last start, saturates at 16'hFFFF.

## Operation
- HALT marker: `instruction[1:0] == 2'b11` (bits unused by `control_unit`). Every other value is executed.
- States:
  - IDLE → FETCH when `start`=1. Loads PC←`start_addr`, clears `instr_count`, `halt_cause`, and `stop_pending`.
  - FETCH: `rom_en`=1, `rom_addr`=PC. Next state LATCH.
  - LATCH: instruction register ← `rom_data`. If the HALT marker is present, go IDLE with cause 01, no `run`, PC unchanged. Otherwise go EXEC.
  - EXEC: `run`=1, wait-counter increments each cycle.
    - `done`=1 → RETIRE.
    - Counter reaches TIMEOUT with no `done` → IDLE with cause 11.
  - RETIRE: `run`=0. PC←PC+1, wrapping 2^ADDR_W−1→0. `instr_count`+1, saturating. Then IDLE with cause 10 if `stop_pending`, else FETCH.
- `stop` is sampled in every non-IDLE state into sticky `stop_pending`. It never interrupts EXEC mid-instruction. It is ignored in IDLE.
- `start` is ignored while `busy`.
- If `stop` and `done` arrive in the same EXEC cycle, the instruction retires and then stops (cause 10).
- Exiting EXEC on `done` drops `run` in the next cycle, so `control_unit` returns to State0 and stays there.

## Timing
- Reset values:
  - State IDLE; PC=0; `instruction`=0.
  - `run`, `rom_en`, `busy`, `halted` all 0.
  - `halt_cause`=00; `instr_count`=0; `stop_pending`=0.
- Mid-operation reset drops `run` asynchronously. `control_unit` shares the same reset and returns to State0.
- Start latency: `start` sampled at edge t → FETCH during cycle t+1, `rom_en` high that cycle.
- `run` rises 2 cycles after FETCH entry. With `control_unit`, `done` arrives in the 6th EXEC cycle.
- Instruction throughput: FETCH 1 + LATCH 1 + EXEC 6 + RETIRE 1 = 9 cycles.
- HALT path: FETCH → LATCH → IDLE. `halted` pulses in the first IDLE cycle, 2 cycles after FETCH.
- Timeout: EXEC lasts exactly TIMEOUT cycles. `run` is low and `halted` pulses in the following cycle.
- All outputs are registered except `rom_addr`, which is a direct copy of the PC register.

## Test plan
- Reset with `start`=1 held → all outputs at reset values; no `rom_en` until reset deasserts.
- ROM[0x10]=16'h2410, ROM[0x11]=16'h0003 (HALT), start at 0x10 → `run` high 6 cycles for one instruction, `instr_count`=1, `halt_cause`=01, PC=0x11, `halted` pulse 9+2 cycles after FETCH.
- ROM[0xFF]=16'h2410, ROM[0x00]=16'h0003, start at 0xFF → PC wraps to 0x00, halts with `instr_count`=1.
- Three non-HALT words; `stop` pulsed during the 2nd instruction's EXEC → the 2nd instruction retires, `instr_count`=2, cause 10, no third `rom_en`.
- `done` tied 0, TIMEOUT=15 → `run` high exactly 15 cycles, cause 11, `instr_count`=0.
- `start` pulsed while busy → ignored, PC sequence unchanged. Reset asserted mid-EXEC → `run`=0 immediately, state IDLE.
